// File: rtl/qr_row_sequencer_pkg.sv
// qr_pkg: shared phase enum, default phase lengths and a helper for the phase counter width.
package qr_pkg;
  typedef enum logic [2:0] {
    QR_IDLE,
    QR_RESET,
    QR_DRIVE,
    QR_SHARE,
    QR_SENSE,
    QR_DONE
  } qr_phase_e;
  localparam int QR_T_RST = 2;
  localparam int QR_T_DRV = 1;
  localparam int QR_T_SHR = 2;
  localparam int QR_T_SA  = 1;
  function automatic int qr_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    m = b > m ? b : m;
    m = c > m ? c : m;
    m = d > m ? d : m;
    return m;
  endfunction
endpackage

// File: rtl/qr_row_sequencer_phase_timer.sv
// qr_phase_timer: loadable down-counter with terminal-count flag and a look-ahead
// flag telling whether the next cycle will be terminal.
module qr_phase_timer #(
  parameter int CW = 3
) (
  input  logic          CLK,
  input  logic          NRST,
  input  logic          i_load,
  input  logic [CW-1:0] i_val,
  output logic          o_tc,
  output logic          o_tc_nxt
);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val - CW'(1);
    else if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
  end
  assign o_tc     = r_cnt == '0;
  assign o_tc_nxt = i_load ? (i_val <= CW'(1)) : (r_cnt <= CW'(1));
endmodule

// File: rtl/qr_row_sequencer.sv
// qr_row_sequencer: per-bit-plane RESET/DRIVE/SHARE/SENSE row sequencer for the CIM macro.
// Optional row masking is enabled by defining QR_ROW_MASK_EN.
module qr_row_sequencer
  import qr_pkg::*;
#(
  parameter int SRAM_ROWS = 128,
  parameter int ACT_BITS  = 4,
  parameter int T_RST     = QR_T_RST,
  parameter int T_DRV     = QR_T_DRV,
  parameter int T_SHR     = QR_T_SHR,
  parameter int T_SA      = QR_T_SA,
  localparam int BW       = ACT_BITS > 1 ? $clog2(ACT_BITS) : 1
) (
  input  logic                          CLK,
  input  logic                          NRST,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [SRAM_ROWS*ACT_BITS-1:0] i_act,
  input  logic                          i_abort,
`ifdef QR_ROW_MASK_EN
  input  logic [SRAM_ROWS-1:0]          i_mask,
`endif
  output logic [SRAM_ROWS-1:0]          VDR_SEL,
  output logic [SRAM_ROWS-1:0]          VDR_SELB,
  output logic [SRAM_ROWS-1:0]          VSS_SEL,
  output logic [SRAM_ROWS-1:0]          VSS_SELB,
  output logic [SRAM_ROWS-1:0]          VRST_SEL,
  output logic [SRAM_ROWS-1:0]          VRST_SELB,
  output logic                          M2A,
  output logic                          M2AB,
  output logic                          R2A,
  output logic                          R2AB,
  output logic                          PCH,
  output logic                          SAEN,
  output logic [BW-1:0]                 o_bit_idx,
  output logic                          o_sa_strobe,
  output logic                          o_done
);
  localparam int CW = $clog2(qr_max4(T_RST, T_DRV, T_SHR, T_SA)) + 1;
  if (T_RST < 1 || T_DRV < 1 || T_SHR < 1 || T_SA < 1) begin : g_chk
    $error("qr_row_sequencer: every phase length must be at least 1");
  end
  qr_phase_e                     r_state, w_nxt;
  logic [SRAM_ROWS*ACT_BITS-1:0] r_act;
  logic [BW-1:0]                 r_bit_idx, w_bit_nxt;
  logic                          r_abort, w_abort_nxt;
  logic                          w_accept, w_load, w_tc, w_tc_nxt, w_drv;
  logic [CW-1:0]                 w_load_val;
  logic [SRAM_ROWS-1:0]          w_plane, w_mask, w_vdr, w_vss, w_vrst;
  logic [ACT_BITS-1:0]           w_row [SRAM_ROWS];
  assign w_accept  = i_valid && o_ready;
  assign o_bit_idx = r_bit_idx;
  qr_phase_timer #(.CW(CW)) u_timer (
    .CLK     (CLK),
    .NRST    (NRST),
    .i_load  (w_load),
    .i_val   (w_load_val),
    .o_tc    (w_tc),
    .o_tc_nxt(w_tc_nxt)
  );
  always_comb begin
    w_nxt       = r_state;
    w_bit_nxt   = r_bit_idx;
    w_abort_nxt = r_abort;
    w_load      = 1'b0;
    w_load_val  = CW'(T_RST);
    if (r_state != QR_IDLE && i_abort) begin
      w_nxt       = QR_RESET;
      w_abort_nxt = 1'b1;
      w_load      = 1'b1;
    end else begin
      case (r_state)
        QR_IDLE: if (w_accept) begin
          w_nxt       = QR_RESET;
          w_bit_nxt   = '0;
          w_abort_nxt = 1'b0;
          w_load      = 1'b1;
        end
        QR_RESET: if (w_tc) begin
          w_nxt       = r_abort ? QR_IDLE : QR_DRIVE;
          w_abort_nxt = 1'b0;
          w_load      = !r_abort;
          w_load_val  = CW'(T_DRV);
        end
        QR_DRIVE: if (w_tc) begin
          w_nxt      = QR_SHARE;
          w_load     = 1'b1;
          w_load_val = CW'(T_SHR);
        end
        QR_SHARE: if (w_tc) begin
          w_nxt      = QR_SENSE;
          w_load     = 1'b1;
          w_load_val = CW'(T_SA);
        end
        QR_SENSE: if (w_tc) begin
          if (r_bit_idx == BW'(ACT_BITS - 1)) w_nxt = QR_DONE;
          else begin
            w_nxt     = QR_RESET;
            w_bit_nxt = r_bit_idx + BW'(1);
            w_load    = 1'b1;
          end
        end
        default: w_nxt = QR_IDLE;
      endcase
    end
  end
  for (genvar g = 0; g < SRAM_ROWS; g++) begin : g_row
    assign w_row[g]   = r_act[g*ACT_BITS +: ACT_BITS];
    assign w_plane[g] = w_row[g][r_bit_idx];
  end
`ifdef QR_ROW_MASK_EN
  logic [SRAM_ROWS-1:0] r_mask;
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) r_mask <= '0;
    else if (w_accept) r_mask <= i_mask;
  end
  assign w_mask = r_mask;
`else
  assign w_mask = '0;
`endif
  // Selects are decoded from the next state so every output leaves a flop.
  assign w_drv  = w_nxt == QR_DRIVE;
  assign w_vdr  = w_drv ? (w_plane & ~w_mask) : '0;
  assign w_vss  = w_drv ? (~w_plane & ~w_mask) : '0;
  assign w_vrst = w_nxt == QR_RESET ? '1 : (w_drv ? w_mask : '0);
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_state     <= QR_IDLE;
      r_bit_idx   <= '0;
      r_abort     <= 1'b0;
      r_act       <= '0;
      o_ready     <= 1'b1;
      o_done      <= 1'b0;
      o_sa_strobe <= 1'b0;
      PCH         <= 1'b0;
      SAEN        <= 1'b0;
      M2A         <= 1'b0;
      M2AB        <= 1'b1;
      R2A         <= 1'b0;
      R2AB        <= 1'b1;
      VDR_SEL     <= '0;
      VDR_SELB    <= '1;
      VSS_SEL     <= '0;
      VSS_SELB    <= '1;
      VRST_SEL    <= '0;
      VRST_SELB   <= '1;
    end else begin
      r_state     <= w_nxt;
      r_bit_idx   <= w_bit_nxt;
      r_abort     <= w_abort_nxt;
      if (w_accept) r_act <= i_act;
      o_ready     <= w_nxt == QR_IDLE;
      o_done      <= w_nxt == QR_DONE;
      o_sa_strobe <= w_nxt == QR_SENSE && w_tc_nxt;
      PCH         <= w_nxt == QR_RESET;
      SAEN        <= w_nxt == QR_SENSE;
      M2A         <= w_nxt == QR_SHARE;
      M2AB        <= w_nxt != QR_SHARE;
      R2A         <= w_nxt == QR_SHARE;
      R2AB        <= w_nxt != QR_SHARE;
      VDR_SEL     <= w_vdr;
      VDR_SELB    <= ~w_vdr;
      VSS_SEL     <= w_vss;
      VSS_SELB    <= ~w_vss;
      VRST_SEL    <= w_vrst;
      VRST_SELB   <= ~w_vrst;
    end
  end
endmodule
